// File: rtl/noncon_rep_checker_pkg.sv
// Shared types for the non-consecutive repetition checker: channel FSM states and fail causes.
// Code 3 (TIMEOUT) only appears in builds with NCR_TIMEOUT_EN defined.
package noncon_rep_pkg;

    localparam int FAIL_CODE_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    typedef enum logic [FAIL_CODE_W-1:0] {
        NONE     = 3'd0,
        EARLY    = 3'd1,
        EXCESS   = 3'd2,
        TIMEOUT  = 3'd3,
        OVERLAP  = 3'd4,
        SPURIOUS = 3'd5
    } fail_code_e;

endpackage

// File: rtl/noncon_rep_checker_if.sv
// Bundle of the checker's observed req/busy/gnt lanes and its per-channel verdicts and totals.
// master drives the observed handshake, slave is the checker.
interface noncon_rep_checker_if #(
    parameter int NUM_CH = 4,
    parameter int STAT_W = 16
);
    import noncon_rep_pkg::*;

    logic [NUM_CH-1:0]             req;
    logic [NUM_CH-1:0]             busy;
    logic [NUM_CH-1:0]             gnt;
    logic [NUM_CH-1:0]             active;
    logic [NUM_CH-1:0]             pass;
    logic [NUM_CH-1:0]             fail;
    logic [FAIL_CODE_W*NUM_CH-1:0] fail_code;
    logic [STAT_W-1:0]             pass_cnt;
    logic [STAT_W-1:0]             fail_cnt;

    modport master (
        output req, busy, gnt,
        input  active, pass, fail, fail_code, pass_cnt, fail_cnt
    );

    modport slave (
        input  req, busy, gnt,
        output active, pass, fail, fail_code, pass_cnt, fail_cnt
    );

endinterface

// File: rtl/noncon_rep_checker_chan.sv
// One channel: counts busy cycles between req and gnt; pass/fail are registered, one cycle after the deciding sample.
// Purely observational, never stalls; NCR_TIMEOUT_EN adds the per-transaction wait limit.
module noncon_rep_chan
    import noncon_rep_pkg::*;
#(
    parameter int REP_N    = 3,
    parameter int MAX_WAIT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       busy,
    input  logic       gnt,
    output logic       active,
    output logic       pass,
    output logic       fail,
    output fail_code_e fail_code
);

    localparam int             CW    = $clog2(REP_N + 1);
    localparam logic [CW-1:0]  C_MAX = CW'(REP_N);

    if (REP_N < 1 || MAX_WAIT < REP_N + 1) begin : g_cfg_err
        $error("noncon_rep_chan: need REP_N >= 1 and MAX_WAIT >= REP_N + 1");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    fail_code_e    code_q, code_d;

`ifdef NCR_TIMEOUT_EN
    localparam int            WW    = $clog2(MAX_WAIT);
    localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT - 1);
    logic [WW-1:0] w_q, w_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= NONE;
`ifdef NCR_TIMEOUT_EN
            w_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
`ifdef NCR_TIMEOUT_EN
            w_q     <= w_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        code_d  = NONE;
`ifdef NCR_TIMEOUT_EN
        w_d     = w_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = COUNT;
                    c_d     = '0;
`ifdef NCR_TIMEOUT_EN
                    w_d     = '0;
`endif
                end else if (gnt) begin
                    fail_d = 1'b1;
                    code_d = SPURIOUS;
                end
            end
            COUNT: begin
`ifdef NCR_TIMEOUT_EN
                // Holds at the limit when a counted busy pre-empts the timeout.
                w_d = (w_q == W_MAX) ? w_q : w_q + 1'b1;
`endif
                if (req) begin
                    state_d = IDLE;
                    fail_d  = 1'b1;
                    code_d  = OVERLAP;
                end else if (gnt) begin
                    state_d = IDLE;
                    if (c_q == C_MAX) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                        code_d = EARLY;
                    end
                end else if (busy) begin
                    if (c_q == C_MAX) begin
                        state_d = IDLE;
                        fail_d  = 1'b1;
                        code_d  = EXCESS;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
`ifdef NCR_TIMEOUT_EN
                else if (w_q == W_MAX) begin
                    state_d = IDLE;
                    fail_d  = 1'b1;
                    code_d  = TIMEOUT;
                end
`endif
                if (state_d == IDLE) begin
                    c_d = '0;
`ifdef NCR_TIMEOUT_EN
                    w_d = '0;
`endif
                end
            end
        endcase
    end

    always_comb begin
        active    = (state_q == COUNT);
        pass      = pass_q;
        fail      = fail_q;
        fail_code = code_q;
    end

endmodule

// File: rtl/noncon_rep_checker.sv
// Multi-channel non-consecutive repetition checker with saturating pass/fail totals (totals lag the pulses by one cycle).
// Observational only, no backpressure; NCR_TIMEOUT_EN enables the per-transaction MAX_WAIT timeout.
module noncon_rep_checker
    import noncon_rep_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int REP_N    = 3,
    parameter int MAX_WAIT = 64,
    parameter int STAT_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    noncon_rep_checker_if.slave  bus
);

    localparam int PW = $clog2(NUM_CH + 1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_cfg_err
        $error("noncon_rep_checker: NUM_CH must be 1..16");
    end

    logic [NUM_CH-1:0]             active_v;
    logic [NUM_CH-1:0]             pass_v;
    logic [NUM_CH-1:0]             fail_v;
    logic [FAIL_CODE_W*NUM_CH-1:0] code_v;
    logic [PW-1:0]                 pass_pop, fail_pop;
    logic [STAT_W-1:0]             pass_cnt_q, fail_cnt_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fail_code_e code_i;

        noncon_rep_chan #(
            .REP_N    (REP_N),
            .MAX_WAIT (MAX_WAIT)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .req       (bus.req[i]),
            .busy      (bus.busy[i]),
            .gnt       (bus.gnt[i]),
            .active    (active_v[i]),
            .pass      (pass_v[i]),
            .fail      (fail_v[i]),
            .fail_code (code_i)
        );

        assign code_v[i*FAIL_CODE_W +: FAIL_CODE_W] = code_i;
    end

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [PW-1:0]     b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + (STAT_W + 1)'(b);
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

    always_comb begin
        pass_pop = '0;
        fail_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pass_pop = pass_pop + PW'(pass_v[i]);
            fail_pop = fail_pop + PW'(fail_v[i]);
        end
    end

    // Every concurrent pulse is summed in one step so simultaneous channels are never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= sat_add(pass_cnt_q, pass_pop);
            fail_cnt_q <= sat_add(fail_cnt_q, fail_pop);
        end
    end

    assign bus.active    = active_v;
    assign bus.pass      = pass_v;
    assign bus.fail      = fail_v;
    assign bus.fail_code = code_v;
    assign bus.pass_cnt  = pass_cnt_q;
    assign bus.fail_cnt  = fail_cnt_q;

endmodule
